inst_mem_loader: RTL

Write-side companion to the byte-addressed, big-endian instruction memory. Accepts 32-bit instruction words over a valid/ready stream and emits them as sequential byte writes to the memory's 8-bit write port, most-significant byte first at the lowest address. The memory's read path then returns exactly the words that were loaded. Used by benches and boot logic to program instruction memory without `$readmemb`.

---
 rtl/inst_mem_loader.sv | 94 +++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-addressed, big-endian memory write port,
// most-significant byte first at the lowest address.
module inst_mem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [15:0]       word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_written
);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       remaining;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic              unused_base_hi;

  // Upper base_addr bits are outside the memory's address space.
  assign unused_base_hi = ^base_addr[31:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (word_count == 16'd0) ? DONE : WAIT_WORD;
      WAIT_WORD: if (in_valid) state_nxt = WRITE;
      WRITE:     if (byte_idx == 2'd3) state_nxt = (remaining == 16'd1) ? DONE : WAIT_WORD;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      remaining     <= 16'd0;
      word          <= 32'd0;
      byte_idx      <= 2'd0;
      words_written <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr           <= base_addr[ADDR_W-1:0];
            remaining     <= word_count;
            words_written <= 16'd0;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            word     <= in_data;
            byte_idx <= 2'd0;
          end
        end
        WRITE: begin
          word     <= {word[23:0], 8'd0};
          ptr      <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            words_written <= words_written + 16'd1;
            remaining     <= remaining - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only from state and registers, so no input reaches an output combinationally.
  assign in_ready  = (state == WAIT_WORD);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = ptr;
  assign mem_wdata = word[31:24];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
